mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the D-side and I-side memory ports onto a single memory bus.
// D wins by default. An I load that keeps losing is promoted once its loss
// count reaches STARVE_LIMIT. A tag ownership table routes accept tags and
// return tags back to the side that issued each load.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      Dmem2arb_command,
  input  logic [XLEN-1:0] Dmem2arb_addr,
  input  logic [63:0]     Dmem2arb_data,
  input  logic [1:0]      Imem2arb_command,
  input  logic [XLEN-1:0] Imem2arb_addr,
  input  logic [3:0]      mem2arb_response,
  input  logic [63:0]     mem2arb_data,
  input  logic [3:0]      mem2arb_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic            d_request,
  output logic [3:0]      arb2Dmem_response,
  output logic [3:0]      arb2Imem_response,
  output logic [3:0]      arb2Dmem_tag,
  output logic [3:0]      arb2Imem_tag,
  output logic [63:0]     arb2mem_data,
  output logic [3:0]      outstanding,
  output logic            spurious_tag
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // Bit 0 of the table is never allocated: tag 0 means "no tag".
  // owner_q bit set = D side owns the tag, clear = I side.
  logic [15:0]   valid_q, valid_d;
  logic [15:0]   owner_q, owner_d;
  logic [SW-1:0] starve_cnt, starve_d;
  logic [3:0]    count_d;

  logic grant_d, grant_i, accepted, alloc, ret_hit, ret_spur, i_load;

  assign i_load = (Imem2arb_command == BUS_LOAD);

  // Grant selection and the muxed request toward memory
  always_comb begin
    grant_d           = 1'b0;
    grant_i           = 1'b0;
    proc2mem_command  = BUS_NONE;
    proc2mem_addr     = '0;
    proc2mem_data     = '0;
    arb2Dmem_response = '0;
    arb2Imem_response = '0;
    if (!reset) begin
      if ((Dmem2arb_command != BUS_NONE) && !((starve_cnt == LIMIT) && i_load))
        grant_d = 1'b1;
      else if (i_load)
        grant_i = 1'b1;
    end
    if (grant_d) begin
      proc2mem_command  = Dmem2arb_command;
      proc2mem_addr     = Dmem2arb_addr;
      proc2mem_data     = Dmem2arb_data;
      arb2Dmem_response = mem2arb_response;
    end else if (grant_i) begin
      proc2mem_command  = Imem2arb_command;
      proc2mem_addr     = Imem2arb_addr;
      arb2Imem_response = mem2arb_response;
    end
  end

  assign d_request    = grant_d;
  assign arb2mem_data = mem2arb_data;
  assign accepted     = (grant_d || grant_i) && (mem2arb_response != 4'd0);
  assign alloc        = accepted && (proc2mem_command == BUS_LOAD);
  assign ret_hit      = !reset && (mem2arb_tag != 4'd0) && valid_q[mem2arb_tag];
  assign ret_spur     = !reset && (mem2arb_tag != 4'd0) && !valid_q[mem2arb_tag];

  // Route a returning tag to the side that owns it; unknown tags go nowhere
  always_comb begin
    arb2Dmem_tag = '0;
    arb2Imem_tag = '0;
    if (ret_hit) begin
      if (owner_q[mem2arb_tag]) arb2Dmem_tag = mem2arb_tag;
      else                      arb2Imem_tag = mem2arb_tag;
    end
  end

  // Next table contents: release on return first so a same-cycle reuse
  // of the tag leaves the entry live under its new owner
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (ret_hit) valid_d[mem2arb_tag] = 1'b0;
    if (alloc) begin
      valid_d[mem2arb_response] = 1'b1;
      owner_d[mem2arb_response] = grant_d;
    end
    valid_d[0] = 1'b0;
    owner_d[0] = 1'b0;
  end

  // Population count of the next table, registered as outstanding
  always_comb begin
    count_d = '0;
    for (int i = 1; i < 16; i++) count_d = count_d + {3'b000, valid_d[i]};
  end

  // Starvation counter: counts I-load losses, cleared by an accepted I request
  always_comb begin
    starve_d = starve_cnt;
    if (grant_i && (mem2arb_response != 4'd0))
      starve_d = '0;
    else if (grant_d && i_load && (starve_cnt != LIMIT))
      starve_d = starve_cnt + 1'b1;
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      owner_q      <= '0;
      starve_cnt   <= '0;
      outstanding  <= '0;
      spurious_tag <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      starve_cnt  <= starve_d;
      outstanding <= count_d;
      if (ret_spur) spurious_tag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random traffic, all
// checked against a tag-ownership reference model held in plain arrays.
module tb_mem_arbiter;
  localparam int XLEN = 32;
  localparam int LIM  = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      Dmem2arb_command, Imem2arb_command;
  logic [XLEN-1:0] Dmem2arb_addr, Imem2arb_addr;
  logic [63:0]     Dmem2arb_data, mem2arb_data;
  logic [3:0]      mem2arb_response, mem2arb_tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data, arb2mem_data;
  logic            d_request, spurious_tag;
  logic [3:0]      arb2Dmem_response, arb2Imem_response;
  logic [3:0]      arb2Dmem_tag, arb2Imem_tag, outstanding;

  mem_arbiter #(.STARVE_LIMIT(LIM), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .Dmem2arb_command(Dmem2arb_command), .Dmem2arb_addr(Dmem2arb_addr),
    .Dmem2arb_data(Dmem2arb_data),
    .Imem2arb_command(Imem2arb_command), .Imem2arb_addr(Imem2arb_addr),
    .mem2arb_response(mem2arb_response), .mem2arb_data(mem2arb_data),
    .mem2arb_tag(mem2arb_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .d_request(d_request),
    .arb2Dmem_response(arb2Dmem_response), .arb2Imem_response(arb2Imem_response),
    .arb2Dmem_tag(arb2Dmem_tag), .arb2Imem_tag(arb2Imem_tag),
    .arb2mem_data(arb2mem_data), .outstanding(outstanding),
    .spurious_tag(spurious_tag)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns each tag (0 none, 1 D, 2 I), I-load loss count,
  // sticky spurious flag.
  int m_owner[16];
  int m_starve;
  bit m_spur;

  logic       last_dreq;
  logic [3:0] last_dresp, last_iresp, last_dtag, last_itag;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    reset            = 1'b0;
    Dmem2arb_command = 2'd0;
    Dmem2arb_addr    = '0;
    Dmem2arb_data    = '0;
    Imem2arb_command = 2'd0;
    Imem2arb_addr    = '0;
    mem2arb_response = '0;
    mem2arb_data     = '0;
    mem2arb_tag      = '0;
  endtask

  // Inputs are already applied; check this cycle, then advance the model
  // and the clock together.
  task automatic cycle();
    int g;
    int cnt;
    logic [3:0] edt, eit;
    #1;
    if (reset) g = 0;
    else if (Dmem2arb_command != 2'd0 && !(m_starve == LIM && Imem2arb_command == 2'd1)) g = 1;
    else if (Imem2arb_command == 2'd1) g = 2;
    else g = 0;

    cnt = 0;
    for (int i = 1; i < 16; i++) if (m_owner[i] != 0) cnt++;
    edt = 4'd0;
    eit = 4'd0;
    if (!reset && mem2arb_tag != 0) begin
      if (m_owner[mem2arb_tag] == 1) edt = mem2arb_tag;
      if (m_owner[mem2arb_tag] == 2) eit = mem2arb_tag;
    end

    chk("cmd",   proc2mem_command, (g == 1) ? Dmem2arb_command : (g == 2) ? Imem2arb_command : 2'd0);
    chk("addr",  proc2mem_addr,    (g == 1) ? Dmem2arb_addr : (g == 2) ? Imem2arb_addr : '0);
    chk("data",  proc2mem_data,    (g == 1) ? Dmem2arb_data : 64'd0);
    chk("dreq",  d_request,        (g == 1));
    chk("dresp", arb2Dmem_response, (g == 1) ? mem2arb_response : 4'd0);
    chk("iresp", arb2Imem_response, (g == 2) ? mem2arb_response : 4'd0);
    chk("dtag",  arb2Dmem_tag, edt);
    chk("itag",  arb2Imem_tag, eit);
    chk("rdata", arb2mem_data, mem2arb_data);
    chk("outst", outstanding, cnt);
    chk("spur",  spurious_tag, m_spur);

    last_dreq  = d_request;
    last_dresp = arb2Dmem_response;
    last_iresp = arb2Imem_response;
    last_dtag  = arb2Dmem_tag;
    last_itag  = arb2Imem_tag;

    if (reset) begin
      for (int i = 0; i < 16; i++) m_owner[i] = 0;
      m_starve = 0;
      m_spur   = 1'b0;
    end else begin
      if (mem2arb_tag != 0) begin
        if (m_owner[mem2arb_tag] != 0) m_owner[mem2arb_tag] = 0;
        else m_spur = 1'b1;
      end
      if (g != 0 && mem2arb_response != 0) begin
        if ((g == 1 ? Dmem2arb_command : Imem2arb_command) == 2'd1)
          m_owner[mem2arb_response] = g;
        if (g == 2) m_starve = 0;
      end
      if (g == 1 && Imem2arb_command == 2'd1 && m_starve < LIM) m_starve++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_owner[i] = 0;
    m_starve = 0;
    m_spur   = 1'b0;
    set_idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    do_reset();
    chk("rst_outst", outstanding, 4'd0);
    chk("rst_spur", spurious_tag, 1'b0);

    // D and I load together, accept tag 3; D wins, then tag 3 returns to D
    Dmem2arb_command = 2'd1; Dmem2arb_addr = 32'h100; Dmem2arb_data = 64'hA5;
    Imem2arb_command = 2'd1; Imem2arb_addr = 32'h200; mem2arb_response = 4'd3;
    cycle();
    chk("r21_dreq", last_dreq, 1'b1);
    chk("r21_dresp", last_dresp, 4'd3);
    chk("r21_iresp", last_iresp, 4'd0);
    set_idle();
    cycle();
    chk("r21_outst1", outstanding, 4'd1);
    mem2arb_tag = 4'd3; mem2arb_data = 64'hDEAD_BEEF;
    cycle();
    chk("r21_dtag", last_dtag, 4'd3);
    chk("r21_itag", last_itag, 4'd0);
    set_idle();
    chk("r21_outst0", outstanding, 4'd0);

    // Six cycles of contention: the fifth goes to I
    do_reset();
    for (int k = 0; k < 6; k++) begin
      Dmem2arb_command = 2'd1; Dmem2arb_addr = 32'h1000 + k;
      Imem2arb_command = 2'd1; Imem2arb_addr = 32'h2000 + k;
      mem2arb_response = 4'(k + 1);
      cycle();
      chk("r22_dreq", last_dreq, (k == 4) ? 1'b0 : 1'b1);
    end
    set_idle();

    // Tag reuse in the same cycle: old I owner gets the return, D the new tag
    do_reset();
    Imem2arb_command = 2'd1; Imem2arb_addr = 32'h40; mem2arb_response = 4'd5;
    cycle();
    set_idle();
    Dmem2arb_command = 2'd1; Dmem2arb_addr = 32'h80; mem2arb_response = 4'd5;
    mem2arb_tag = 4'd5;
    cycle();
    chk("r23_itag", last_itag, 4'd5);
    chk("r23_dresp", last_dresp, 4'd5);
    set_idle();
    mem2arb_tag = 4'd5;
    cycle();
    chk("r23_dtag", last_dtag, 4'd5);
    set_idle();

    // Return of a tag nobody owns
    do_reset();
    mem2arb_tag = 4'd7;
    cycle();
    chk("r24_dtag", last_dtag, 4'd0);
    chk("r24_itag", last_itag, 4'd0);
    set_idle();
    cycle();
    cycle();
    chk("r24_spur_held", spurious_tag, 1'b1);

    // Accepted store does not allocate
    do_reset();
    Dmem2arb_command = 2'd2; Dmem2arb_addr = 32'h300; Dmem2arb_data = 64'h1234;
    mem2arb_response = 4'd2;
    cycle();
    set_idle();
    cycle();
    chk("r25_outst", outstanding, 4'd0);
    mem2arb_tag = 4'd2;
    cycle();
    set_idle();
    chk("r25_spur", spurious_tag, 1'b1);

    // Reset with three loads in flight kills them
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      Dmem2arb_command = 2'd1; Dmem2arb_addr = 32'(k * 16); mem2arb_response = 4'(k);
      cycle();
    end
    chk("r26_outst3", outstanding, 4'd3);
    reset = 1'b1; mem2arb_tag = 4'd1;
    cycle();
    chk("r26_rst_dreq", last_dreq, 1'b0);
    chk("r26_rst_dresp", last_dresp, 4'd0);
    chk("r26_rst_dtag", last_dtag, 4'd0);
    set_idle();
    chk("r26_outst0", outstanding, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      mem2arb_tag = 4'(k);
      cycle();
      chk("r26_dtag", last_dtag, 4'd0);
      chk("r26_itag", last_itag, 4'd0);
    end
    set_idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(0, 99) == 0);
      Dmem2arb_command = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'($urandom_range(1, 2));
      Dmem2arb_addr    = $urandom;
      Dmem2arb_data    = {$urandom, $urandom};
      Imem2arb_command = 2'($urandom_range(0, 1));
      Imem2arb_addr    = $urandom;
      mem2arb_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem2arb_data     = {$urandom, $urandom};
      mem2arb_tag      = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      cycle();
    end
    set_idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without completing at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
